// File: rtl/tt_eval_pkg.sv
// Shared types and constants for the truth-table evaluation engine.
package tt_eval_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [7:0] TT_DEFAULT_3 = 8'h92;

endpackage

// File: rtl/tt_eval_engine_if.sv
// Configuration, stream, result and status signals of the evaluation engine.
interface tt_eval_engine_if #(
   parameter int N_IN = 3
);
   localparam int TT_W = 2**N_IN;

   logic            cfg_valid;
   logic [TT_W-1:0] cfg_tt;
   logic            cfg_ready;
   logic            start;
   logic            in_valid;
   logic [N_IN-1:0] in_vec;
   logic            in_ready;
   logic            out_valid;
   logic            out_ready;
   logic            out_bit;
   logic [N_IN-1:0] out_idx;
   logic            out_src;
   logic            busy;
   logic            done;
   logic [N_IN:0]   ones_cnt;

   modport master (
      output cfg_valid, cfg_tt, start, in_valid, in_vec, out_ready,
      input  cfg_ready, in_ready, out_valid, out_bit, out_idx, out_src, busy, done, ones_cnt
   );

   modport slave (
      input  cfg_valid, cfg_tt, start, in_valid, in_vec, out_ready,
      output cfg_ready, in_ready, out_valid, out_bit, out_idx, out_src, busy, done, ones_cnt
   );

endinterface

// File: rtl/tt_out_slice.sv
// Single-entry output register with valid/ready handshake; holds its contents
// while the consumer stalls.
module tt_out_slice #(
   parameter int N_IN = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_valid,
   input  logic            load_bit,
   input  logic [N_IN-1:0] load_idx,
   input  logic            load_src,
   input  logic            out_ready,
   output logic            out_valid,
   output logic            out_bit,
   output logic [N_IN-1:0] out_idx,
   output logic            out_src,
   output logic            slot_free,
   output logic            accept
);

   logic            valid_r;
   logic            bit_r;
   logic [N_IN-1:0] idx_r;
   logic            src_r;

   assign slot_free = !valid_r || out_ready;
   assign accept    = valid_r && out_ready;

   // Result register: refills whenever the slot is empty or being drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= 1'b0;
         bit_r   <= 1'b0;
         idx_r   <= '0;
         src_r   <= 1'b0;
      end else if (slot_free) begin
         valid_r <= load_valid;
         if (load_valid) begin
            bit_r <= load_bit;
            idx_r <= load_idx;
            src_r <= load_src;
         end
      end
   end

   assign out_valid = valid_r;
   assign out_bit   = bit_r;
   assign out_idx   = idx_r;
   assign out_src   = src_r;

endmodule

// File: rtl/tt_eval_engine.sv
// Truth-table evaluator: one-cycle stream lookups in IDLE, or an exhaustive
// in-order sweep of the whole table with popcount of the emitted ones.
module tt_eval_engine
   import tt_eval_pkg::*;
#(
   parameter int              N_IN     = 3,
   parameter int              TT_W     = 2**N_IN,
   parameter logic [TT_W-1:0] RESET_TT = TT_W'(TT_DEFAULT_3)
) (
   input logic             clk,
   input logic             rst,
   tt_eval_engine_if.slave bus
);

   localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT_W - 1);

   state_t          state_r;
   state_t          state_s;
   logic [N_IN-1:0] idx_r;
   logic [N_IN-1:0] idx_s;
   logic [TT_W-1:0] table_r;
   logic [N_IN:0]   ones_r;
   logic            done_r;
   logic            done_s;
   logic            busy_r;

   logic            load_valid_s;
   logic            load_bit_s;
   logic [N_IN-1:0] load_idx_s;
   logic            load_src_s;

   logic            out_valid_s;
   logic            out_bit_s;
   logic [N_IN-1:0] out_idx_s;
   logic            out_src_s;
   logic            slot_free_s;
   logic            accept_s;

   logic            idle_s;
   logic            cfg_ready_s;
   logic            in_ready_s;
   logic            cfg_fire_s;
   logic            in_fire_s;
   logic            start_fire_s;

   assign idle_s       = (state_r == IDLE);
   assign cfg_ready_s  = idle_s && !out_valid_s;
   assign in_ready_s   = idle_s && slot_free_s;
   assign cfg_fire_s   = bus.cfg_valid && cfg_ready_s;
   assign in_fire_s    = bus.in_valid && in_ready_s;
   // A table load in the same cycle wins over a sweep request.
   assign start_fire_s = bus.start && cfg_ready_s && !cfg_fire_s;

   // Next-state, sweep index and output-register load selection.
   always_comb begin
      state_s      = state_r;
      idx_s        = idx_r;
      done_s       = 1'b0;
      load_valid_s = 1'b0;
      load_bit_s   = 1'b0;
      load_idx_s   = '0;
      load_src_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_fire_s) begin
               load_valid_s = 1'b1;
               load_bit_s   = table_r[bus.in_vec];
               load_idx_s   = bus.in_vec;
               load_src_s   = 1'b0;
            end else begin
               load_valid_s = 1'b0;
            end
            if (start_fire_s) begin
               state_s = SWEEP;
               idx_s   = '0;
            end else begin
               state_s = IDLE;
            end
         end
         SWEEP: begin
            if (slot_free_s) begin
               load_valid_s = 1'b1;
               load_bit_s   = table_r[idx_r];
               load_idx_s   = idx_r;
               load_src_s   = 1'b1;
               if (idx_r == LAST_IDX) begin
                  state_s = DRAIN;
               end else begin
                  idx_s = idx_r + N_IN'(1);
               end
            end else begin
               load_valid_s = 1'b0;
            end
         end
         DRAIN: begin
            // Only the final sweep result can sit in the register here.
            if (accept_s) begin
               done_s  = 1'b1;
               state_s = IDLE;
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Control state, table, popcount and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         idx_r   <= '0;
         table_r <= RESET_TT;
         ones_r  <= '0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         done_r  <= done_s;
         busy_r  <= (state_s != IDLE);
         if (cfg_fire_s) begin
            table_r <= bus.cfg_tt;
         end
         if (start_fire_s) begin
            ones_r <= '0;
         end else if (accept_s && out_src_s && out_bit_s) begin
            ones_r <= ones_r + (N_IN+1)'(1);
         end
      end
   end

   tt_out_slice #(
      .N_IN (N_IN)
   ) u_out_slice (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid_s),
      .load_bit   (load_bit_s),
      .load_idx   (load_idx_s),
      .load_src   (load_src_s),
      .out_ready  (bus.out_ready),
      .out_valid  (out_valid_s),
      .out_bit    (out_bit_s),
      .out_idx    (out_idx_s),
      .out_src    (out_src_s),
      .slot_free  (slot_free_s),
      .accept     (accept_s)
   );

   assign bus.cfg_ready = cfg_ready_s;
   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_bit   = out_bit_s;
   assign bus.out_idx   = out_idx_s;
   assign bus.out_src   = out_src_s;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.ones_cnt  = ones_r;

endmodule

// File: tb/tb_tt_eval_engine.sv
// Directed and randomized checks of tt_eval_engine against a table-lookup
// reference model held in the bench.
module tb_tt_eval_engine;

   localparam int N_IN = 3;
   localparam int TT_W = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   int              n_chk = 0;
   int              n_fail = 0;
   logic [TT_W-1:0] model_tt;
   int              exp_q[$];

   tt_eval_engine_if #(.N_IN(N_IN)) bus ();

   tt_eval_engine #(.N_IN(N_IN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic stream_one(input logic [N_IN-1:0] vec, input string tag);
      logic expb;
      expb = model_tt[vec];
      bus.in_valid  = 1'b1;
      bus.in_vec    = vec;
      bus.out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      check({tag, "_valid"}, bus.out_valid, 1);
      check({tag, "_bit"}, bus.out_bit, expb);
      check({tag, "_idx"}, bus.out_idx, vec);
      check({tag, "_src"}, bus.out_src, 0);
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      check("drain_valid", bus.out_valid, 0);
   endtask

   task automatic load_tt(input logic [TT_W-1:0] tt);
      check("load_cfg_ready", bus.cfg_ready, 1);
      bus.cfg_valid = 1'b1;
      bus.cfg_tt    = tt;
      step();
      bus.cfg_valid = 1'b0;
      bus.cfg_tt    = $urandom;
      model_tt      = tt;
   endtask

   // mode 0: always ready, 1: ready every third cycle, otherwise random
   task automatic run_sweep(input int mode, input string tag);
      int              got[$];
      int              dones;
      int              cyc;
      int              pc;
      logic            stalled;
      logic [N_IN-1:0] p_idx;
      logic            p_bit;
      logic            p_src;
      dones   = 0;
      cyc     = 0;
      stalled = 1'b0;
      pc      = 0;
      for (int k = 0; k < TT_W; k++) pc += int'(model_tt[k]);
      check({tag, "_cfg_ready"}, bus.cfg_ready, 1);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check({tag, "_busy"}, bus.busy, 1);
      while (dones == 0 && cyc < 400) begin
         check({tag, "_in_ready_low"}, bus.in_ready, 0);
         check({tag, "_cfg_ready_low"}, bus.cfg_ready, 0);
         if (stalled) begin
            check({tag, "_hold_valid"}, bus.out_valid, 1);
            check({tag, "_hold_idx"}, bus.out_idx, p_idx);
            check({tag, "_hold_bit"}, bus.out_bit, p_bit);
            check({tag, "_hold_src"}, bus.out_src, p_src);
         end
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 3 == 0);
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (bus.out_valid && bus.out_ready) begin
            check({tag, "_src"}, bus.out_src, 1);
            got.push_back(int'(bus.out_idx) * 2 + int'(bus.out_bit));
         end
         stalled = bus.out_valid && !bus.out_ready;
         p_idx   = bus.out_idx;
         p_bit   = bus.out_bit;
         p_src   = bus.out_src;
         step();
         cyc++;
         if (bus.done) dones++;
      end
      check({tag, "_done_seen"}, dones, 1);
      check({tag, "_count"}, got.size(), TT_W);
      for (int k = 0; k < TT_W && k < got.size(); k++) begin
         check({tag, "_order_idx"}, got[k] / 2, k);
         check({tag, "_order_bit"}, got[k] % 2, model_tt[k]);
      end
      check({tag, "_ones_cnt"}, bus.ones_cnt, pc);
      check({tag, "_busy_after"}, bus.busy, 0);
      bus.out_ready = 1'b1;
      step();
      check({tag, "_done_pulse"}, bus.done, 0);
      check({tag, "_ones_hold"}, bus.ones_cnt, pc);
      check({tag, "_idle_in_ready"}, bus.in_ready, 1);
   endtask

   task automatic random_stream(input int cycles);
      int   e;
      logic ov;
      logic exp_in_ready;
      logic exp_cfg_ready;
      for (int c = 0; c < cycles; c++) begin
         ov = bus.out_valid;
         check("rs_valid_vs_model", ov, (exp_q.size() != 0));
         if (ov && exp_q.size() != 0) begin
            e = exp_q[0];
            check("rs_idx", bus.out_idx, e / 2);
            check("rs_bit", bus.out_bit, e % 2);
            check("rs_src", bus.out_src, 0);
         end
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_vec    = N_IN'($urandom_range(0, TT_W - 1));
         bus.out_ready = 1'($urandom_range(0, 3) != 0);
         bus.cfg_valid = ($urandom_range(0, 7) == 0);
         bus.cfg_tt    = TT_W'($urandom);
         #1;
         exp_in_ready  = !ov || bus.out_ready;
         exp_cfg_ready = !ov;
         check("rs_in_ready", bus.in_ready, exp_in_ready);
         check("rs_cfg_ready", bus.cfg_ready, exp_cfg_ready);
         if (ov && bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         if (bus.in_valid && exp_in_ready)
            exp_q.push_back(int'(bus.in_vec) * 2 + int'(model_tt[bus.in_vec]));
         if (bus.cfg_valid && exp_cfg_ready) model_tt = bus.cfg_tt;
         step();
      end
      bus.in_valid  = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.out_ready = 1'b1;
      check("rs_final_valid", bus.out_valid, (exp_q.size() != 0));
      if (bus.out_valid && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("rs_final_bit", bus.out_bit, e % 2);
      end
      step();
      check("rs_drained", bus.out_valid, 0);
   endtask

   initial begin
      int n;
      bus.cfg_valid = 1'b0;
      bus.cfg_tt    = '0;
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_vec    = '0;
      bus.out_ready = 1'b0;
      model_tt      = 8'h92;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_bit", bus.out_bit, 0);
      check("rst_out_idx", bus.out_idx, 0);
      check("rst_out_src", bus.out_src, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_ones", bus.ones_cnt, 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", bus.in_ready, 1);
      check("post_rst_cfg_ready", bus.cfg_ready, 1);

      // Back-to-back stream lookups with the reset table
      stream_one(3'b100, "s100");
      stream_one(3'b011, "s011");
      drain();

      // Full sweep of the reset table
      run_sweep(0, "sweep92");

      // Majority table
      load_tt(8'hE8);
      run_sweep(0, "sweepE8");
      stream_one(3'b110, "maj110");
      drain();

      // Stalling consumer
      load_tt(8'h92);
      run_sweep(1, "sweep_stall");

      // Load and start together: load wins, no sweep
      bus.cfg_valid = 1'b1;
      bus.cfg_tt    = 8'h5A;
      bus.start     = 1'b1;
      #1;
      check("ls_cfg_ready", bus.cfg_ready, 1);
      step();
      bus.cfg_valid = 1'b0;
      bus.start     = 1'b0;
      model_tt      = 8'h5A;
      check("ls_busy0", bus.busy, 0);
      step();
      check("ls_busy1", bus.busy, 0);
      check("ls_no_out", bus.out_valid, 0);
      stream_one(3'b001, "ls_v1");
      stream_one(3'b000, "ls_v0");
      drain();

      // Randomized stream traffic with occasional table loads
      random_stream(150);

      // Random tables swept against a random consumer
      for (int r = 0; r < 3; r++) begin
         load_tt(TT_W'($urandom));
         run_sweep(2, "sweep_rand");
      end

      // Reset in the middle of a sweep
      load_tt(8'hE8);
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      step();
      bus.start = 1'b0;
      n = 0;
      while (!(bus.out_valid && bus.out_idx == 3'd4) && n < 40) begin
         step();
         n++;
      end
      check("mid_reached_idx4", bus.out_idx, 4);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_done", bus.done, 0);
      step();
      check("mid_rst_done2", bus.done, 0);
      check("mid_rst_ones", bus.ones_cnt, 0);
      rst      = 1'b0;
      model_tt = 8'h92;
      #1;
      check("mid_post_in_ready", bus.in_ready, 1);
      check("mid_post_cfg_ready", bus.cfg_ready, 1);
      step();
      check("mid_post_done", bus.done, 0);
      stream_one(3'b001, "mid_v1");
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
